// File: rtl/csa_4_2_accumulator_pkg.sv
// Shared types for the 4:2 carry-save accumulator: beat classification used by the
// top-level next-state logic.
package csa_4_2_accumulator_pkg;

    typedef enum logic [1:0] {
        BeatNone,
        BeatDirect,
        BeatAccum,
        BeatLast
    } beat_e;

    // Last is only meaningful on accumulate beats.
    function automatic beat_e classify_beat(logic accept, logic acc, logic last);
        if (!accept) begin
            return BeatNone;
        end
        if (!acc) begin
            return BeatDirect;
        end
        return last ? BeatLast : BeatAccum;
    endfunction

endpackage

// File: rtl/csa_4_2_accumulator_if.sv
// Input-beat and result handshake bundle for csa_4_2_accumulator.
interface csa_4_2_accumulator_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] in_d;
    logic             in_acc;
    logic             in_last;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_carry;
    logic [CNT_W-1:0] out_beats;

    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_acc, in_last, acc_clear, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_beats
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_acc, in_last, acc_clear, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_beats
    );
endinterface

// File: rtl/csa_4_2_row.sv
// Combinational row of WIDTH 4:2 compressor slices; sum + carry == a + b + c + d mod 2^WIDTH.
module csa_4_2_row #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] k1;
    logic [WIDTH-1:0] k2;

    assign k1[0]      = 1'b0;
    assign k2[0]      = 1'b0;
    assign carry_o[0] = 1'b0;

    // cout1 depends only on this slice's a,b,c, so the lateral chain never ripples.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign s1[i]    = a_i[i] ^ b_i[i] ^ c_i[i];
        assign s2[i]    = s1[i] ^ d_i[i] ^ k1[i];
        assign sum_o[i] = s2[i] ^ k2[i];
        if (i < WIDTH - 1) begin : g_cout
            assign k1[i+1]      = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
            assign k2[i+1]      = (s1[i] & d_i[i]) | (s1[i] & k1[i]) | (d_i[i] & k1[i]);
            assign carry_o[i+1] = s2[i] & k2[i];
        end
    end
endmodule

// File: rtl/csa_4_2_accumulator.sv
// 4:2 carry-save compressor with a registered redundant output, valid/ready handshake
// and an accumulate mode that feeds the stored sum/carry pair back as operands c,d.
module csa_4_2_accumulator
    import csa_4_2_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    csa_4_2_accumulator_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
    } red_t;

    localparam red_t             RedZero = '0;
    localparam logic [CNT_W-1:0] CntMax  = '1;

    red_t             acc_q, acc_d;
    logic [CNT_W-1:0] acc_n_q, acc_n_d;
    red_t             out_q, out_d;
    logic [CNT_W-1:0] out_n_q, out_n_d;
    logic             out_valid_q, out_valid_d;

    red_t             src;
    red_t             row;
    logic [CNT_W-1:0] n0;
    logic [CNT_W-1:0] n_inc;
    logic [WIDTH-1:0] row_c;
    logic [WIDTH-1:0] row_d;
    logic             in_ready;
    beat_e            beat;

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_q.s;
    assign bus.out_carry = out_q.c;
    assign bus.out_beats = out_n_q;

    // A clear in the same cycle as an accumulate beat starts the group afresh.
    assign src   = bus.acc_clear ? RedZero : acc_q;
    assign n0    = bus.acc_clear ? '0 : acc_n_q;
    assign n_inc = (n0 == CntMax) ? n0 : n0 + CNT_W'(1);
    assign row_c = bus.in_acc ? src.s : bus.in_c;
    assign row_d = bus.in_acc ? src.c : bus.in_d;
    assign beat  = classify_beat(bus.in_valid && in_ready, bus.in_acc, bus.in_last);

    csa_4_2_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .a_i     (bus.in_a),
        .b_i     (bus.in_b),
        .c_i     (row_c),
        .d_i     (row_d),
        .sum_o   (row.s),
        .carry_o (row.c)
    );

    always_comb begin
        acc_d       = src;
        acc_n_d     = n0;
        out_d       = out_q;
        out_n_d     = out_n_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        unique case (beat)
            BeatNone: begin
            end
            BeatDirect: begin
                out_d       = row;
                out_n_d     = CNT_W'(1);
                out_valid_d = 1'b1;
            end
            BeatAccum: begin
                acc_d   = row;
                acc_n_d = n_inc;
            end
            BeatLast: begin
                out_d       = row;
                out_n_d     = n_inc;
                out_valid_d = 1'b1;
                acc_d       = RedZero;
                acc_n_d     = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= RedZero;
            acc_n_q     <= '0;
            out_q       <= RedZero;
            out_n_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_n_q     <= acc_n_d;
            out_q       <= out_d;
            out_n_q     <= out_n_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_csa_4_2_accumulator.sv
// Directed and randomized checks of csa_4_2_accumulator (WIDTH=8, CNT_W=2) against an
// arithmetic reference model.
module tb_csa_4_2_accumulator;
    localparam int unsigned W = 8;
    localparam int unsigned N = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    csa_4_2_accumulator_if #(.WIDTH(W), .CNT_W(N)) bus ();

    csa_4_2_accumulator #(
        .WIDTH (W),
        .CNT_W (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: accumulated true value and beat count, plus expected result queues.
    int m_acc;
    int m_n;
    int q_sum[$];
    int q_beats[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_value();
        return (32'(bus.out_sum) + 32'(bus.out_carry)) & 32'hFF;
    endfunction

    task automatic check_out(input string tag, input int exp_sum, input int exp_beats);
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_sum"}, dut_value(), exp_sum);
        check({tag, "_beats"}, 32'(bus.out_beats), exp_beats);
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.acc_clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic acc, input logic last, input logic clr,
                        input int a, input int b, input int c, input int d);
        int k;
        bus.in_valid  = 1'b1;
        bus.in_acc    = acc;
        bus.in_last   = last;
        bus.acc_clear = clr;
        bus.in_a      = W'(a);
        bus.in_b      = W'(b);
        bus.in_c      = W'(c);
        bus.in_d      = W'(d);
        #1;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!bus.in_ready) begin
            check("send_ready_timeout", 32'(bus.in_ready), 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.acc_clear = 1'b0;
    endtask

    initial begin
        int exp_s;
        int exp_b;
        int s0;
        int n0;
        logic ready_exp;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_acc = 1'b0; bus.in_last = 1'b0; bus.acc_clear = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_sum", 32'(bus.out_sum), 0);
        check("rst_carry", 32'(bus.out_carry), 0);
        check("rst_beats", 32'(bus.out_beats), 0);
        check("rst_ready", 32'(bus.in_ready), 1);

        // Plain 4-operand beat, latency one.
        send(1'b0, 1'b0, 1'b0, 1, 2, 3, 4);
        check_out("direct", 10, 1);
        idle();
        check("direct_drop", 32'(bus.out_valid), 0);

        // Three-beat accumulation group.
        send(1'b1, 1'b0, 1'b0, 10, 20, 0, 0);
        check("grp_b1_valid", 32'(bus.out_valid), 0);
        send(1'b1, 1'b0, 1'b0, 30, 40, 0, 0);
        check("grp_b2_valid", 32'(bus.out_valid), 0);
        send(1'b1, 1'b1, 1'b0, 50, 60, 0, 0);
        check_out("grp", 210, 3);
        send(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        check_out("grp_acc_zero", 0, 1);

        send(1'b0, 1'b0, 1'b0, 255, 255, 255, 255);
        check_out("wrap", 8'hFC, 1);
        idle();

        // Back-pressure: hold five cycles, then consume and reload together.
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 5, 6, 7, 8);
        check_out("hold_load", 26, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_ready", 32'(bus.in_ready), 0);
            check_out("hold", 26, 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1, 1, 1, 1);
        check_out("reload", 4, 1);
        idle();
        check("reload_drop", 32'(bus.out_valid), 0);

        // Clear together with an accumulate beat, then reset mid-group.
        send(1'b1, 1'b0, 1'b0, 1, 1, 0, 0);
        send(1'b1, 1'b1, 1'b1, 2, 3, 0, 0);
        check_out("clr", 5, 1);
        send(1'b1, 1'b0, 1'b0, 7, 7, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid", 32'(bus.out_valid), 0);
        send(1'b1, 1'b1, 1'b0, 4, 4, 0, 0);
        check_out("midrst", 8, 1);

        // Beat counter saturation.
        for (int i = 0; i < 5; i++) begin
            send(1'b1, (i == 4), 1'b0, 1, 0, 0, 0);
        end
        check_out("sat", 5, 3);
        idle();

        // Randomized traffic against the model.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_acc = 0;
        m_n   = 0;
        q_sum.delete();
        q_beats.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_acc    = ($urandom_range(0, 2) != 0);
            bus.in_last   = ($urandom_range(0, 3) == 0);
            bus.acc_clear = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_a = W'($urandom); bus.in_b = W'($urandom);
            bus.in_c = W'($urandom); bus.in_d = W'($urandom);
            #1;
            check("rnd_valid", 32'(bus.out_valid), 32'(q_sum.size() != 0));
            ready_exp = (q_sum.size() == 0) || bus.out_ready;
            check("rnd_ready", 32'(bus.in_ready), 32'(ready_exp));
            if (bus.out_valid && bus.out_ready && q_sum.size() != 0) begin
                exp_s = q_sum.pop_front();
                exp_b = q_beats.pop_front();
                check("rnd_sum", dut_value(), exp_s);
                check("rnd_beats", 32'(bus.out_beats), exp_b);
            end
            s0 = bus.acc_clear ? 0 : m_acc;
            n0 = bus.acc_clear ? 0 : m_n;
            m_acc = s0;
            m_n   = n0;
            if (bus.in_valid && ready_exp) begin
                if (!bus.in_acc) begin
                    q_sum.push_back((int'(bus.in_a) + int'(bus.in_b) + int'(bus.in_c)
                                     + int'(bus.in_d)) % 256);
                    q_beats.push_back(1);
                end else begin
                    exp_s = (int'(bus.in_a) + int'(bus.in_b) + s0) % 256;
                    exp_b = (n0 + 1 > 3) ? 3 : n0 + 1;
                    if (bus.in_last) begin
                        q_sum.push_back(exp_s);
                        q_beats.push_back(exp_b);
                        m_acc = 0;
                        m_n   = 0;
                    end else begin
                        m_acc = exp_s;
                        m_n   = exp_b;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
